// File: rtl/demux12_reg_5_bit_pkg.sv
// ============================================================================
// Module : demux12_reg_5_bit_pkg
// Brief  : Shared constants and types for the registered 1-to-2 token demux.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package demux12_reg_5_bit_pkg;

  localparam int DEFAULT_WIDTH = 5;

  localparam logic SEL_OUT1 = 1'b0;
  localparam logic SEL_OUT2 = 1'b1;

  // Per-port holding-register state; the encoding doubles as the valid flag.
  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;

  typedef logic [DEFAULT_WIDTH-1:0] token_t;

endpackage

`default_nettype wire

// File: rtl/demux12_reg_5_bit_out_slot.sv
// ============================================================================
// Module : out_slot_5_bit
// Brief  : One-entry valid/ready holding register; optional handshake counter
//          under DEMUX_CNT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module out_slot_5_bit
  import demux12_reg_5_bit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
`ifdef DEMUX_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             free_o
`ifdef DEMUX_CNT_EN
  , output logic [CNT_W-1:0] cnt_o
`endif
);

  logic             state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // A load wins over a drain so that drain+refill keeps the slot full.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (load_i) begin
      state_d = ST_FULL;
      data_d  = data_i;
    end else if ((state_q == ST_FULL) && ready_i) begin
      state_d = ST_EMPTY;
    end
  end

  always_comb begin
    valid_o = (state_q == ST_FULL);
    free_o  = (state_q == ST_EMPTY) | ready_i;
  end

  assign data_o = data_q;

`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == ST_FULL) && ready_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
`endif

endmodule

`default_nettype wire

// File: rtl/demux12_reg_5_bit.sv
// ============================================================================
// Module : demux12_reg_5_bit
// Brief  : Registered 1-to-2 valid/ready demux for register-address tokens.
//          Optional per-port handshake counters under DEMUX_CNT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module demux12_reg_5_bit
  import demux12_reg_5_bit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             clk_,
  input  logic             rst_n_,
  input  logic             in_valid_,
  output logic             in_ready_,
  input  logic [WIDTH-1:0] in_data_,
  input  logic             in_sel_,
  output logic             out1_valid_,
  input  logic             out1_ready_,
  output logic [WIDTH-1:0] out1_data_,
  output logic             out2_valid_,
  input  logic             out2_ready_,
  output logic [WIDTH-1:0] out2_data_
`ifdef DEMUX_CNT_EN
  , output logic [CNT_W-1:0] out1_cnt_
  , output logic [CNT_W-1:0] out2_cnt_
`endif
);

  if ((WIDTH < 1) || (CNT_W < 1)) begin : g_param_check
    $error("demux12_reg_5_bit: WIDTH and CNT_W must be positive");
  end

  logic w_free1, w_free2;
  logic w_accept;
  logic w_load1, w_load2;

  // Only the targeted slot gates the input: head-of-line blocking keeps order.
  assign in_ready_ = (in_sel_ == SEL_OUT2) ? w_free2 : w_free1;
  assign w_accept  = in_valid_ & in_ready_;
  assign w_load1   = w_accept & (in_sel_ == SEL_OUT1);
  assign w_load2   = w_accept & (in_sel_ == SEL_OUT2);

  out_slot_5_bit #(
    .WIDTH (WIDTH)
`ifdef DEMUX_CNT_EN
    , .CNT_W (CNT_W)
`endif
  ) u_slot1 (
    .clk_i   (clk_),
    .rst_n_i (rst_n_),
    .load_i  (w_load1),
    .data_i  (in_data_),
    .ready_i (out1_ready_),
    .valid_o (out1_valid_),
    .data_o  (out1_data_),
    .free_o  (w_free1)
`ifdef DEMUX_CNT_EN
    , .cnt_o (out1_cnt_)
`endif
  );

  out_slot_5_bit #(
    .WIDTH (WIDTH)
`ifdef DEMUX_CNT_EN
    , .CNT_W (CNT_W)
`endif
  ) u_slot2 (
    .clk_i   (clk_),
    .rst_n_i (rst_n_),
    .load_i  (w_load2),
    .data_i  (in_data_),
    .ready_i (out2_ready_),
    .valid_o (out2_valid_),
    .data_o  (out2_data_),
    .free_o  (w_free2)
`ifdef DEMUX_CNT_EN
    , .cnt_o (out2_cnt_)
`endif
  );

endmodule

`default_nettype wire

// File: tb/tb_demux12_reg_5_bit.sv
// ============================================================================
// Module : tb_demux12_reg_5_bit
// Brief  : Directed self-checking bench for demux12_reg_5_bit (DEMUX_CNT_EN
//          enables the counter-wrap section with CNT_W=4).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_demux12_reg_5_bit;

  localparam int WIDTH = 5;
`ifdef DEMUX_CNT_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 16;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             out1_valid, out1_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out2_valid, out2_ready;
  logic [WIDTH-1:0] out2_data;
`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0] out1_cnt, out2_cnt;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  demux12_reg_5_bit #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk_        (clk),
    .rst_n_      (rst_n),
    .in_valid_   (in_valid),
    .in_ready_   (in_ready),
    .in_data_    (in_data),
    .in_sel_     (in_sel),
    .out1_valid_ (out1_valid),
    .out1_ready_ (out1_ready),
    .out1_data_  (out1_data),
    .out2_valid_ (out2_valid),
    .out2_ready_ (out2_ready),
    .out2_data_  (out2_data)
`ifdef DEMUX_CNT_EN
    , .out1_cnt_ (out1_cnt)
    , .out2_cnt_ (out2_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic s);
    in_valid = v;
    in_data  = d;
    in_sel   = s;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b1, 5'h1F, 1'b0);
    out1_ready = 1'b1;
    out2_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    drive(1'b0, 5'h00, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0);
    out1_ready = 1'b0;
    out2_ready = 1'b0;

    // ---------------- reset, with in_valid asserted throughout
    do_reset();
    check("rst_out1_valid", 32'(out1_valid), 32'd0);
    check("rst_out2_valid", 32'(out2_valid), 32'd0);
    check("rst_out1_data",  32'(out1_data),  32'd0);
    check("rst_out2_data",  32'(out2_data),  32'd0);
`ifdef DEMUX_CNT_EN
    check("rst_out1_cnt", 32'(out1_cnt), 32'd0);
    check("rst_out2_cnt", 32'(out2_cnt), 32'd0);
`endif
    tick();
    check("idle_out1_valid", 32'(out1_valid), 32'd0);
    check("idle_out2_valid", 32'(out2_valid), 32'd0);

    // ---------------- routing
    drive(1'b1, 5'h0A, 1'b0);
    #1 check("route_in_ready0", 32'(in_ready), 32'd1);
    tick();
    check("route_o1_valid", 32'(out1_valid), 32'd1);
    check("route_o1_data",  32'(out1_data),  32'h0A);
    check("route_o2_idle",  32'(out2_valid), 32'd0);
    drive(1'b1, 5'h15, 1'b1);
    tick();
    check("route_o2_valid", 32'(out2_valid), 32'd1);
    check("route_o2_data",  32'(out2_data),  32'h15);
    check("route_o1_drop",  32'(out1_valid), 32'd0);
    check("route_o1_hold",  32'(out1_data),  32'h0A);
    drive(1'b0, 5'h00, 1'b0);
    tick();
    check("route_o2_drop",  32'(out2_valid), 32'd0);

    // ---------------- backpressure on out1
    out1_ready = 1'b0;
    drive(1'b1, 5'h03, 1'b0);
    tick();
    check("bp_o1_first", 32'(out1_data), 32'h03);
    drive(1'b1, 5'h04, 1'b0);
    #1 check("bp_in_ready_lo", 32'(in_ready), 32'd0);
    tick();
    check("bp_o1_valid_hold", 32'(out1_valid), 32'd1);
    check("bp_o1_data_hold",  32'(out1_data),  32'h03);
    out1_ready = 1'b1;
    #1 check("bp_in_ready_hi", 32'(in_ready), 32'd1);
    tick();
    check("bp_o1_second_v", 32'(out1_valid), 32'd1);
    check("bp_o1_second",   32'(out1_data),  32'h04);
    drive(1'b0, 5'h00, 1'b0);
    tick();
    check("bp_o1_drained", 32'(out1_valid), 32'd0);

    // ---------------- head-of-line
    out1_ready = 1'b0;
    drive(1'b1, 5'h07, 1'b0);
    tick();
    check("hol_o1_full", 32'(out1_data), 32'h07);
    drive(1'b1, 5'h1F, 1'b1);
    #1 check("hol_in_ready_sel1", 32'(in_ready), 32'd1);
    tick();
    check("hol_o2_valid", 32'(out2_valid), 32'd1);
    check("hol_o2_data",  32'(out2_data),  32'h1F);
    drive(1'b1, 5'h08, 1'b0);
    #1 check("hol_in_ready_sel0", 32'(in_ready), 32'd0);
    tick();
    check("hol_o1_stuck", 32'(out1_data),  32'h07);
    check("hol_o2_drop",  32'(out2_valid), 32'd0);
    check("hol_still_lo", 32'(in_ready),   32'd0);
    out1_ready = 1'b1;
    #1 check("hol_release", 32'(in_ready), 32'd1);
    tick();
    check("hol_o1_new", 32'(out1_data), 32'h08);
    drive(1'b0, 5'h00, 1'b0);
    tick();
    check("hol_o1_empty", 32'(out1_valid), 32'd0);

    // ---------------- streaming 0..31, alternating ports, no bubbles
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 5'(i), i[0]);
      #1 check($sformatf("strm_rdy%0d", i), 32'(in_ready), 32'd1);
      tick();
      if (i[0]) begin
        check($sformatf("strm_o2_%0d", i), {26'd0, out2_valid, out2_data}, {26'd0, 1'b1, 5'(i)});
        check($sformatf("strm_o1off_%0d", i), 32'(out1_valid), 32'd0);
      end else begin
        check($sformatf("strm_o1_%0d", i), {26'd0, out1_valid, out1_data}, {26'd0, 1'b1, 5'(i)});
        if (i > 0) check($sformatf("strm_o2off_%0d", i), 32'(out2_valid), 32'd0);
      end
    end
    drive(1'b0, 5'h00, 1'b0);
    tick();
    check("strm_end_o1", 32'(out1_valid), 32'd0);
    check("strm_end_o2", 32'(out2_valid), 32'd0);

    // ---------------- reset discards a held token
    out1_ready = 1'b0;
    drive(1'b1, 5'h11, 1'b0);
    tick();
    check("rst2_pre_full", 32'(out1_valid), 32'd1);
    do_reset();
    check("rst2_o1_valid", 32'(out1_valid), 32'd0);
    check("rst2_o1_data",  32'(out1_data),  32'd0);

`ifdef DEMUX_CNT_EN
    // ---------------- counter wrap at CNT_W=4: 17 handshakes -> 1
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 5'(i), 1'b0);
      tick();
    end
    drive(1'b0, 5'h00, 1'b0);
    tick();
    check("cnt_o1_wrap", 32'(out1_cnt), 32'd1);
    check("cnt_o2_zero", 32'(out2_cnt), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/demux12_reg_5_bit.md
Name: demux12_reg_5_bit

Overview:
- Registered 1-to-2 demultiplexer for 5-bit register-address tokens; the inverse of the 2-to-1 destination-register select.
- Takes one valid/ready input stream and steers each token to one of two valid/ready output ports according to a per-token select bit.
- Each output has a one-entry holding register, giving 1-cycle latency and full backpressure.
- Sits between decode and two write-back consumers, e.g. the register-file write port and the hazard/forwarding unit.

Parameters:
- WIDTH, 5, bit width of the data token (register address).
- CNT_W, 16, width of the optional transfer counters.

Ports:
- clk_  input  1  clock; all state updates on the rising edge.
- rst_n_  input  1  synchronous active-low reset.
- in_valid_  input  1  input token valid.
- in_ready_  output  1  input can accept; combinational.
- in_data_  input  WIDTH  input token.
- in_sel_  input  1  0 routes to output 1, 1 routes to output 2; sampled with the token.
- out1_valid_  output  1  output 1 holds a token.
- out1_ready_  input  1  output 1 consumer accepts.
- out1_data_  output  WIDTH  output 1 token.
- out2_valid_  output  1  output 2 holds a token.
- out2_ready_  input  1  output 2 consumer accepts.
- out2_data_  output  WIDTH  output 2 token.
- out1_cnt_  output  CNT_W  output 1 handshakes completed; present only with DEMUX_CNT_EN.
- out2_cnt_  output  CNT_W  output 2 handshakes completed; present only with DEMUX_CNT_EN.

Behaviour:
- Reset (rst_n_=0 at a clock edge): outN_valid_=0, outN_data_=0, counters=0. Reset overrides any handshake in the same cycle; a held token is discarded.
- Slot k is free when ~outk_valid_ | outk_ready_, so a drain and a refill can happen in the same cycle.
- in_ready_ = in_sel_ ? slot2_free : slot1_free.
- in_ready_ is purely combinational; the block adds no registered stall.
- Accept occurs when in_valid_ & in_ready_. At that edge, outk_data_ <= in_data_ and outk_valid_ <= 1, with k = in_sel_+1.
- Drain: if outk_valid_ & outk_ready_ and no accept targets k, then outk_valid_ <= 0. outk_data_ holds its last value.
- Simultaneous drain and accept on the same port: outk_valid_ stays 1 and outk_data_ takes the new token. Throughput is 1 token/cycle.
- Stall: while outk_valid_ & ~outk_ready_, outk_data_ and outk_valid_ are held stable (AXI-style; valid never drops without a handshake).
- Head-of-line blocking is intentional. If the targeted slot is full, the input stalls even when the other slot is empty, which preserves program order per source.
- The non-targeted port is unaffected by an accept on the other port. Both ports may drain in the same cycle.
- Latency is exactly 1 cycle from accept to outk_valid_=1.
- in_data_ and in_sel_ are don't-care when in_valid_=0. in_ready_ may toggle with in_sel_ while in_valid_=0.
- State per port is EMPTY (valid=0) and FULL (valid=1):
  - EMPTY→FULL on accept.
  - FULL→EMPTY on drain without accept.
  - FULL→FULL on stall or on drain with accept.

Optional Feature:
- Macro DEMUX_CNT_EN.
- Defined: ports out1_cnt_ and out2_cnt_ exist. outk_cnt_ increments by 1 on each cycle with outk_valid_ & outk_ready_, and wraps modulo 2^CNT_W (0xFFFF+1 → 0x0000 at default width). Counters reset to 0.
- Undefined: the ports and counter logic are absent, with no other behavioural difference.

Decomposition:
- Shared package holds:
  - localparam DEFAULT_WIDTH=5;
  - SEL_OUT1=1'b0 and SEL_OUT2=1'b1;
  - a typedef for the token (logic [WIDTH-1:0]).
- One natural sub-module, out_slot_5_bit: the one-entry valid/ready holding register with optional counter, instantiated twice.

Test Plan:
- Reset: hold rst_n_=0 for 2 cycles with in_valid_=1 → out1_valid_=out2_valid_=0, data=0, counters=0 after release.
- Routing: send 5'h0A sel=0 then 5'h15 sel=1 with both readies=1 → out1_data_=0x0A one cycle after the first accept; out2_data_=0x15 the following cycle; each valid for exactly 1 cycle.
- Backpressure: out1_ready_=0, send 5'h03 sel=0 then 5'h04 sel=0 → out1_data_ holds 0x03 and in_ready_=0 with sel=0. Raise ready → 0x03 then 0x04 are delivered back-to-back with no loss.
- Head-of-line: out1 full and stalled, present 5'h1F sel=1 → in_ready_=1 and out2 receives 0x1F. Then present sel=0 → in_ready_=0 until out1_ready_=1.
- Streaming: 32 consecutive tokens 0..31 alternating sel, readies=1 → one accept per cycle, in-order per port, no bubbles.
- With DEMUX_CNT_EN and CNT_W=4: 17 handshakes on out1 → out1_cnt_=1 (wrap); out2_cnt_ unchanged.
